// File: rtl/hs_master_arbiter_if.sv
// Client-side and slave-side handshake signals for hs_master_arbiter.
//   master modport : the arbiter (samples client requests and ack, drives
//                    completion pulses, req and data_out)
//   slave  modport : everything on the other side (clients + downstream slave)
// Signals:
//   cli_valid[NUM_CLI]   client i has a byte pending
//   cli_data[8*NUM_CLI]  client i byte at [8i+7:8i]
//   cli_done[NUM_CLI]    one-cycle pulse, byte delivered
//   cli_err[NUM_CLI]     one-cycle pulse, transfer aborted on timeout
//   req / data_out       4-phase request and byte towards the slave
//   ack                  4-phase acknowledge from the slave
interface hs_master_arbiter_if #(
  parameter int NUM_CLI = 4
);
  logic [NUM_CLI-1:0]   cli_valid;
  logic [NUM_CLI*8-1:0] cli_data;
  logic [NUM_CLI-1:0]   cli_done;
  logic [NUM_CLI-1:0]   cli_err;
  logic                 req;
  logic [7:0]           data_out;
  logic                 ack;

  modport master (
    input  cli_valid, cli_data, ack,
    output cli_done, cli_err, req, data_out
  );

  modport slave (
    output cli_valid, cli_data, ack,
    input  cli_done, cli_err, req, data_out
  );
endinterface

// File: rtl/hs_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4-phase req/ack byte channel
// between NUM_CLI clients. The winner's byte is captured at grant, req is held
// until ack rises (or TIMEOUT expires), then the arbiter waits for ack to fall
// before pulsing cli_done / cli_err and returning to IDLE.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   bus          hs_master_arbiter_if.master (client and slave handshake)
//   busy         high whenever the FSM is not in IDLE
//   grant_id     index of current or last granted client
//   xfer_count   completed transfers, wraps modulo 2^CNT_W
module hs_master_arbiter #(
  parameter int NUM_CLI = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hs_master_arbiter_if.master  bus,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic [CNT_W-1:0]     xfer_count
);

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DROP = 2'd2,
    ABORT     = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [2:0]           rr_ptr, rr_n;
  logic [WC_W-1:0]      wcnt, wcnt_n;
  logic                 req_q, req_n;
  logic [7:0]           data_q, data_n;
  logic [NUM_CLI-1:0]   done_q, done_n;
  logic [NUM_CLI-1:0]   err_q, err_n;
  logic                 busy_n;
  logic [2:0]           gid_n;
  logic [CNT_W-1:0]     cnt_n;

  // Arbitration: rotate the request vector so rr_ptr lands at bit 0, pick the
  // lowest set bit, then rotate the offset back into a client index.
  logic [2*NUM_CLI-1:0] dbl, shifted;
  logic [NUM_CLI-1:0]   rot;
  logic                 any_req;
  logic [2:0]           win_off, win_id;
  logic [3:0]           wsum;
  logic [7:0]           win_byte;
  logic [NUM_CLI-1:0]   gnt_oh;
  logic [2:0]           rr_next;

  assign dbl     = {bus.cli_valid, bus.cli_valid};
  assign shifted = dbl >> rr_ptr;
  assign rot     = shifted[NUM_CLI-1:0];

  always_comb begin
    any_req = |rot;
    win_off = '0;
    for (int j = NUM_CLI-1; j >= 0; j--) begin
      if (rot[j]) win_off = 3'(j);
    end
    wsum = {1'b0, rr_ptr} + {1'b0, win_off};
    if (wsum >= 4'(NUM_CLI)) wsum = wsum - 4'(NUM_CLI);
    win_id = wsum[2:0];
  end

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_CLI; i++) begin
      if (win_id == 3'(i)) win_byte = bus.cli_data[i*8 +: 8];
    end
  end

  // Completion pulses always target the client that holds the grant.
  always_comb begin
    for (int i = 0; i < NUM_CLI; i++) gnt_oh[i] = (grant_id == 3'(i));
  end

  assign rr_next = (grant_id == 3'(NUM_CLI-1)) ? 3'd0 : grant_id + 3'd1;

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    wcnt_n  = wcnt;
    req_n   = req_q;
    data_n  = data_q;
    done_n  = '0;
    err_n   = '0;
    busy_n  = busy;
    gid_n   = grant_id;
    cnt_n   = xfer_count;
    case (state)
      IDLE: begin
        req_n  = 1'b0;
        busy_n = 1'b0;
        if (any_req) begin
          gid_n   = win_id;
          data_n  = win_byte;
          req_n   = 1'b1;
          busy_n  = 1'b1;
          wcnt_n  = '0;
          state_n = REQ;
        end
      end
      REQ: begin
        req_n = 1'b1;
        if (bus.ack) begin
          req_n   = 1'b0;
          state_n = WAIT_DROP;
        end else if (TIMEOUT != 0 && wcnt == WC_LAST) begin
          req_n   = 1'b0;
          state_n = ABORT;
        end else begin
          wcnt_n = wcnt + WC_W'(1);
        end
      end
      WAIT_DROP: begin
        // No timeout here: a slave stuck with ack high parks us in this state.
        req_n = 1'b0;
        if (!bus.ack) begin
          done_n  = gnt_oh;
          cnt_n   = xfer_count + CNT_W'(1);
          rr_n    = rr_next;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      ABORT: begin
        req_n = 1'b0;
        if (!bus.ack) begin
          err_n   = gnt_oh;
          rr_n    = rr_next;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        req_n   = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      wcnt       <= '0;
      req_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= '0;
      err_q      <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      xfer_count <= '0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_n;
      wcnt       <= wcnt_n;
      req_q      <= req_n;
      data_q     <= data_n;
      done_q     <= done_n;
      err_q      <= err_n;
      busy       <= busy_n;
      grant_id   <= gid_n;
      xfer_count <= cnt_n;
    end
  end

  assign bus.req      = req_q;
  assign bus.data_out = data_q;
  assign bus.cli_done = done_q;
  assign bus.cli_err  = err_q;

endmodule

// File: doc/hs_master_arbiter.md
Name: hs_master_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4-phase req/ack byte channel between NUM_CLI clients.
- Accepts a byte from the winning client and drives req/data_out to the downstream slave FSM.
- Completes the full handshake: req high until ack high, req low until ack low.
- Reports per-client completion or timeout, and keeps a transfer count for debug.

Parameters:
- NUM_CLI, 4, number of requesting clients (2..8).
- TIMEOUT, 64, max cycles waiting for ack rise in REQ; 0 disables timeout.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cli_valid  in  NUM_CLI  client i has a byte pending; held until cli_done[i] or cli_err[i].
- cli_data  in  NUM_CLI*8  client i byte at bits [8i+7:8i].
- cli_done  out  NUM_CLI  one-cycle pulse: client i byte accepted (handshake complete).
- cli_err  out  NUM_CLI  one-cycle pulse: client i transfer aborted on timeout.
- req  out  1  handshake request to slave.
- data_out  out  8  byte to slave; stable whenever req=1.
- ack  in  1  handshake acknowledge from slave.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  3  index of current or last granted client.
- xfer_count  out  CNT_W  completed transfers; wraps modulo 2^CNT_W.

Behaviour:
- Outputs are registered. Reset, asynchronous on rst_n low:
  - state=IDLE, rr_ptr=0.
  - req, data_out, cli_done, cli_err, busy, grant_id, xfer_count all 0.
- Reset mid-transfer aborts it immediately: req drops asynchronously and no done/err pulse is issued.
- Arbitration, in IDLE with any cli_valid set:
  - Winner = first set bit scanning rr_ptr, rr_ptr+1, … modulo NUM_CLI.
  - Next edge: grant_id<=winner, data_out<=its byte, req<=1, busy<=1, state->REQ.
  - req therefore rises 1 cycle after valid is sampled.
- REQ: req=1, data_out held.
  - ack=1 sampled: req<=0, state->WAIT_DROP.
  - Else if TIMEOUT!=0 and wait counter reaches TIMEOUT-1: req<=0, state->ABORT.
  - Wait counter clears on entry to REQ.
- WAIT_DROP: req=0.
  - On ack=0 sampled: cli_done[grant_id]<=1 for one cycle, xfer_count<=xfer_count+1, rr_ptr<=(grant_id+1) mod NUM_CLI, state->IDLE, busy<=0.
  - No timeout here; an ack stuck high holds WAIT_DROP.
- ABORT: req=0.
  - On ack=0: cli_err[grant_id] pulses, rr_ptr advances as on success, xfer_count unchanged, state->IDLE.
- IDLE is re-entered for at least one cycle between transfers, so req low spans ≥2 cycles. This guarantees the slave returns to its wait state before the next req.
- cli_data changes after grant are ignored; the byte is captured at grant.
- A cli_valid drop before done is ignored; the transfer completes anyway.
- cli_valid bits rising while busy are served at the next IDLE, in round-robin order.
- At most one cli_done/cli_err bit is set in any cycle.
- Against the standard slave, worst-case transfer is ≈6 cycles grant-to-done: ack rises 1 cycle after req and holds 2 cycles.
- State encoding: IDLE, REQ, WAIT_DROP, ABORT; illegal encodings recover to IDLE.

Test Plan:
- Reset, then cli_valid=4'b0001 with byte 0xA5:
  - req rises next cycle with data_out=0xA5.
  - Slave latches last_byte=0xA5.
  - cli_done[0] pulses once; xfer_count=1.
- cli_valid=4'b1111 held, bytes 0x10/0x21/0x32/0x43:
  - Grants in order 0,1,2,3,0.
  - Slave last_byte sequence is 0x10,0x21,0x32,0x43,0x10.
  - No two done pulses in the same cycle.
- ack tied 0, TIMEOUT=8, cli_valid=4'b0100:
  - req high exactly 8 cycles, then low.
  - cli_err[2] pulses once; xfer_count unchanged; rr_ptr=3.
- Client 1 changes cli_data 0x55->0xAA one cycle after grant: slave receives 0x55.
- rst_n low while in WAIT_DROP with ack=1:
  - All outputs are 0 immediately.
  - No done pulse; after release, arbitration restarts from client 0.
- xfer_count forced near wrap (CNT_W=4, 16 transfers): count reads 0 after the 16th done.
